tic_tac_toe_game_ctrl: RTL and testbench
========================================

# tic_tac_toe_game_ctrl

Turn sequencer for a two-player tic-tac-toe game. The block owns the X and O board registers and accepts one move at a time from a shared move port over a valid/ready handshake. It enforces alternation and move legality, detects win, draw and move timeout, and presents the board and game status to display/UI logic.

## Interface
- `FIRST_O`, 0: 0 means X moves first; 1 means O moves first.
- `TIMEOUT_CYCLES`, 1000: cycles a player may hold the turn before forfeiting; 0 disables the timeout.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  level-sampled; clears the board and begins a new game.
- `move_valid`  in  1  requester presents a move.
- `move_pos`  in  4  cell index 0-8, row-major (0 = top-left, 8 = bottom-right).
- `move_ready`  out  1  controller can accept a move this cycle.
- `board_x`  out  9  X-occupied cells.
- `board_o`  out  9  O-occupied cells.
- `turn_o`  out  1  1 when O is to move; meaningful only in turn states.
- `move_count`  out  4  legal moves accepted in the current game, 0-9.
- `illegal_move`  out  1  one-cycle pulse when a rejected move occurs.
- `game_over`  out  1  high in every result state.
- `winner_x`, `winner_o`, `draw`, `timed_out`  out  1 each  result flags; valid while `game_over` is high.

## Operation
- States: IDLE, TURN_X, TURN_O, CHECK, WIN_X, WIN_O, DRAW.
- IDLE:
  - `start` leads to TURN_X, or to TURN_O when `FIRST_O` is 1.
  - Boards and count are cleared on that transition.
- TURN_*:
  - `move_ready` = 1 and `start` = 0.
  - A transfer occurs when `move_valid & move_ready`.
  - A move is legal when `move_pos` ≤ 8 and the cell is empty in both boards.
  - Legal move: set the mover's bit, increment `move_count`, record the mover, go to CHECK.
  - Illegal move: boards are unchanged, the state does not change, and `illegal_move` pulses on the next cycle.
- CHECK (exactly one cycle), evaluated on the registered boards:
  - Mover has three in a row: go to WIN_X or WIN_O.
  - Else `move_count` == 9: go to DRAW.
  - Else go to the opponent's TURN state.
- Result states:
  - Boards hold and `move_ready` = 0.
  - `start` clears everything and goes to the first TURN state.
- Win lines: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}.
- Timeout:
  - A cycle counter is cleared on entry to each TURN state and increments every cycle in that state.
  - If it reaches `TIMEOUT_CYCLES` - 1 with no transfer, the next state is the opponent's WIN state, with `timed_out` = 1.
  - A transfer in that same cycle takes priority over the timeout.
- `start` in a TURN or CHECK state aborts the game: clear and restart. `start` has priority over a simultaneous move; `move_ready` is forced low while `start` is high.
- Reset (any time, including mid-game): state IDLE, all outputs 0, counters 0.

## Timing
- All outputs are registered, except `move_ready`, which is decoded from the state and `start`.
- Accepted move at edge N:
  - Board bit and `move_count` update at N.
  - CHECK occupies the cycle after N.
  - The result or next TURN state is entered at edge N+1.
  - `move_ready` is next high two cycles after acceptance.
- `illegal_move` is high for exactly the one cycle following the rejected transfer.
- Result flags assert on the same edge as entry into the result state and hold until `start` or `rst`.
- Maximum game length is 9 accepts plus 9 CHECK cycles, plus wait time.

## Structure
- Package `tic_tac_toe_pkg` holds:
  - `state_t` enum.
  - `NUM_CELLS` = 9 and `CELL_IDX_W` = 4.
  - `WIN_MASKS`: eight 9-bit line masks.
- Sub-module `tic_tac_toe_line_detect`: one 9-bit board in, 1-bit three-in-a-row out, purely combinational. It is instantiated twice, once for `board_x` and once for `board_o`.

## Test plan
- X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 → after the last CHECK, `winner_x` = 1, `board_x` = 9'h007, `board_o` = 9'h018, `move_count` = 5.
- Full-board draw:
  - Sequence: X4, O0, X2, O6, X3, O5, X7, O1, X8.
  - Required: `draw` = 1, `move_count` = 9, `board_x` | `board_o` = 9'h1FF.
- Occupied cell and pos = 12:
  - X plays 4, then O plays 4, then O plays 12.
  - Required: two `illegal_move` pulses, `board_o` = 0, `turn_o` still 1.
- `TIMEOUT_CYCLES` = 8, start, X never moves → on the 8th TURN_X cycle, go to WIN_O with `timed_out` = 1.
- `start` and `move_valid` asserted together in TURN_X → move dropped, boards 0, `move_count` 0.
- `rst` pulsed mid-CHECK → state IDLE immediately, all outputs 0, `move_ready` 0 until `start`.

Source files
------------

// File: rtl/tic_tac_toe_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
package tic_tac_toe_pkg;

  localparam int unsigned NUM_CELLS  = 9;
  localparam int unsigned CELL_IDX_W = 4;
  localparam int unsigned NUM_LINES  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN_X = 3'd1,
    TURN_O = 3'd2,
    CHECK  = 3'd3,
    WIN_X  = 3'd4,
    WIN_O  = 3'd5,
    DRAW   = 3'd6
  } state_t;

  // Bit i of a mask is cell i (row-major); rows, columns, then diagonals.
  localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_MASKS = {
    9'h054, 9'h111,         // diagonals {2,4,6}, {0,4,8}
    9'h124, 9'h092, 9'h049, // columns {2,5,8}, {1,4,7}, {0,3,6}
    9'h1C0, 9'h038, 9'h007  // rows {6,7,8}, {3,4,5}, {0,1,2}
  };

  function automatic logic is_turn(input state_t s);
    return (s == TURN_X) || (s == TURN_O);
  endfunction

endpackage

// File: rtl/tic_tac_toe_line_detect.sv
// Flags a board that holds any complete three-in-a-row line.
module tic_tac_toe_line_detect
  import tic_tac_toe_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board,
  output logic                 line_c
);

  // Any win mask fully covered by the board.
  always_comb begin
    line_c = 1'b0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if ((board & WIN_MASKS[i]) == WIN_MASKS[i]) line_c = 1'b1;
    end
  end

endmodule

// File: rtl/tic_tac_toe_game_ctrl.sv
// Tic-tac-toe turn sequencer: owns both boards, accepts moves, detects results.
module tic_tac_toe_game_ctrl
  import tic_tac_toe_pkg::*;
#(
  parameter bit          FIRST_O        = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  move_valid,
  input  logic [CELL_IDX_W-1:0] move_pos,
  output logic                  move_ready,
  output logic [NUM_CELLS-1:0]  board_x,
  output logic [NUM_CELLS-1:0]  board_o,
  output logic                  turn_o,
  output logic [3:0]            move_count,
  output logic                  illegal_move,
  output logic                  game_over,
  output logic                  winner_x,
  output logic                  winner_o,
  output logic                  draw,
  output logic                  timed_out
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam state_t FIRST_TURN = FIRST_O ? TURN_O : TURN_X;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 mover_o_q, mover_o_d;
  logic [NUM_CELLS-1:0] board_x_d, board_o_d, cell_mask;
  logic [3:0]           move_count_d;
  logic                 illegal_d, game_over_d, winner_x_d, winner_o_d, draw_d, timed_out_d;
  logic                 legal, timeout_hit, x_line, o_line;

  tic_tac_toe_line_detect u_line_x (.board(board_x), .line_c(x_line));
  tic_tac_toe_line_detect u_line_o (.board(board_o), .line_c(o_line));

  assign move_ready = is_turn(state_q) && !start;

  // Move legality and timeout decode.
  always_comb begin
    cell_mask   = NUM_CELLS'(1) << move_pos;
    legal       = (move_pos <= CELL_IDX_W'(NUM_CELLS - 1)) && ((board_x | board_o) & cell_mask) == '0;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  // Next-state and next-output logic; start clears and restarts from any state.
  always_comb begin
    state_d      = state_q;
    board_x_d    = board_x;
    board_o_d    = board_o;
    move_count_d = move_count;
    mover_o_d    = mover_o_q;
    illegal_d    = 1'b0;
    game_over_d  = game_over;
    winner_x_d   = winner_x;
    winner_o_d   = winner_o;
    draw_d       = draw;
    timed_out_d  = timed_out;
    timer_d      = '0;

    if (start) begin
      state_d      = FIRST_TURN;
      board_x_d    = '0;
      board_o_d    = '0;
      move_count_d = '0;
      game_over_d  = 1'b0;
      winner_x_d   = 1'b0;
      winner_o_d   = 1'b0;
      draw_d       = 1'b0;
      timed_out_d  = 1'b0;
    end else begin
      unique case (state_q)
        TURN_X, TURN_O: begin
          if (move_valid) begin
            if (legal) begin
              if (state_q == TURN_O) board_o_d = board_o | cell_mask;
              else                   board_x_d = board_x | cell_mask;
              move_count_d = move_count + 4'd1;
              mover_o_d    = (state_q == TURN_O);
              state_d      = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end else if (timeout_hit) begin
            state_d     = (state_q == TURN_O) ? WIN_X : WIN_O;
            winner_x_d  = (state_q == TURN_O);
            winner_o_d  = (state_q == TURN_X);
            timed_out_d = 1'b1;
            game_over_d = 1'b1;
          end
        end
        CHECK: begin
          if (mover_o_q ? o_line : x_line) begin
            state_d     = mover_o_q ? WIN_O : WIN_X;
            winner_o_d  = mover_o_q;
            winner_x_d  = !mover_o_q;
            game_over_d = 1'b1;
          end else if (move_count == 4'(NUM_CELLS)) begin
            state_d     = DRAW;
            draw_d      = 1'b1;
            game_over_d = 1'b1;
          end else begin
            state_d = mover_o_q ? TURN_X : TURN_O;
          end
        end
        IDLE, WIN_X, WIN_O, DRAW: state_d = state_q;
        default:                  state_d = IDLE;
      endcase
    end

    // Turn timer restarts on every entry (including a start-driven re-entry).
    if (is_turn(state_q) && (state_d == state_q) && !start) timer_d = timer_q + TMR_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      mover_o_q    <= 1'b0;
      board_x      <= '0;
      board_o      <= '0;
      turn_o       <= 1'b0;
      move_count   <= '0;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      winner_x     <= 1'b0;
      winner_o     <= 1'b0;
      draw         <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mover_o_q    <= mover_o_d;
      board_x      <= board_x_d;
      board_o      <= board_o_d;
      turn_o       <= (state_d == TURN_O);
      move_count   <= move_count_d;
      illegal_move <= illegal_d;
      game_over    <= game_over_d;
      winner_x     <= winner_x_d;
      winner_o     <= winner_o_d;
      draw         <= draw_d;
      timed_out    <= timed_out_d;
    end
  end

endmodule

// File: tb/tb_tic_tac_toe_game_ctrl.sv
// Scoreboard bench for tic_tac_toe_game_ctrl: stimulus queues expectations, monitor checks.
module tb_tic_tac_toe_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, move_valid;
  logic [3:0] move_pos;
  logic       move_ready, turn_o, illegal_move, game_over;
  logic       winner_x, winner_o, draw, timed_out;
  logic [8:0] board_x, board_o;
  logic [3:0] move_count;

  always #5 clk = ~clk;

  tic_tac_toe_game_ctrl #(.FIRST_O(1'b0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_pos(move_pos),
    .move_ready(move_ready), .board_x(board_x), .board_o(board_o), .turn_o(turn_o),
    .move_count(move_count), .illegal_move(illegal_move), .game_over(game_over),
    .winner_x(winner_x), .winner_o(winner_o), .draw(draw), .timed_out(timed_out)
  );

  localparam int K_ILL  = 0;  // illegal_move pulse
  localparam int K_RES  = 1;  // game_over rising
  localparam int K_SNAP = 2;  // bench-requested snapshot

  typedef struct {
    int         kind;
    logic [8:0] bx;
    logic [8:0] bo;
    logic [3:0] cnt;
    logic       wx, wo, dr, to, tn, rdy, go;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic snap_req = 1'b0;
  logic go_prev  = 1'b0;

  function automatic exp_t mk(input int kind, input logic [8:0] bx, input logic [8:0] bo,
                              input logic [3:0] cnt, input logic wx, input logic wo,
                              input logic dr, input logic to, input logic tn,
                              input logic rdy, input logic go);
    exp_t e;
    e.kind = kind; e.bx = bx; e.bo = bo; e.cnt = cnt;
    e.wx = wx; e.wo = wo; e.dr = dr; e.to = to; e.tn = tn; e.rdy = rdy; e.go = go;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_event(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind %0d want none (t=%0t)", kind, $time);
      return;
    end
    e = q.pop_front();
    chk("kind", 16'(kind), 16'(e.kind));
    chk("board_x", 16'(board_x), 16'(e.bx));
    chk("board_o", 16'(board_o), 16'(e.bo));
    chk("move_count", 16'(move_count), 16'(e.cnt));
    if (kind == K_ILL) begin
      chk("turn_o", 16'(turn_o), 16'(e.tn));
    end else begin
      chk("winner_x", 16'(winner_x), 16'(e.wx));
      chk("winner_o", 16'(winner_o), 16'(e.wo));
      chk("draw", 16'(draw), 16'(e.dr));
      chk("timed_out", 16'(timed_out), 16'(e.to));
      chk("game_over", 16'(game_over), 16'(e.go));
      if (kind == K_SNAP) chk("move_ready", 16'(move_ready), 16'(e.rdy));
    end
  endtask

  // Monitor: pops one expectation per observed DUT event.
  initial begin
    forever begin
      @(negedge clk);
      if (illegal_move) check_event(K_ILL);
      if (game_over && !go_prev) check_event(K_RES);
      if (snap_req) check_event(K_SNAP);
      go_prev = game_over;
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    @(negedge clk); #1;
    snap_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_move(input logic [3:0] pos);
    int n = 0;
    while (!move_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!move_ready) begin
      total++; bad++;
      $display("FAIL move_ready_wait: got 0 want 1 (pos %0d)", pos);
      return;
    end
    move_valid = 1'b1;
    move_pos   = pos;
    @(posedge clk); #1;
    move_valid = 1'b0;
  endtask

  task automatic wait_over(input int limit, output int cycles);
    cycles = 0;
    while (!game_over && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
    total++;
    if (!game_over) begin
      bad++;
      $display("FAIL game_over_wait: got 0 want 1 after %0d cycles", cycles);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; move_valid = 1'b0; move_pos = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    q.push_back(mk(K_SNAP, 9'h000, 9'h000, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    snap();

    // X wins on the top row.
    pulse_start();
    q.push_back(mk(K_RES, 9'h007, 9'h018, 4'd5, 1, 0, 0, 0, 0, 0, 1));
    do_move(4'd0); do_move(4'd3); do_move(4'd1); do_move(4'd4); do_move(4'd2);
    wait_over(10, cyc);

    // Full-board draw.
    pulse_start();
    q.push_back(mk(K_RES, 9'h19C, 9'h063, 4'd9, 0, 0, 1, 0, 0, 0, 1));
    do_move(4'd4); do_move(4'd0); do_move(4'd2); do_move(4'd6); do_move(4'd3);
    do_move(4'd5); do_move(4'd7); do_move(4'd1); do_move(4'd8);
    wait_over(10, cyc);

    // Occupied cell then out-of-range index: two rejections, O still to move.
    pulse_start();
    q.push_back(mk(K_ILL, 9'h010, 9'h000, 4'd1, 0, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(K_ILL, 9'h010, 9'h000, 4'd1, 0, 0, 0, 0, 1, 0, 0));
    do_move(4'd4); do_move(4'd4); do_move(4'd12);

    // X never moves: O wins by timeout on the 8th TURN_X cycle.
    pulse_start();
    q.push_back(mk(K_RES, 9'h000, 9'h000, 4'd0, 0, 1, 0, 1, 0, 0, 1));
    wait_over(20, cyc);
    chk("timeout_cycles", 16'(cyc), 16'd8);

    // start together with a move in TURN_X: move dropped, ready low while start high.
    pulse_start();
    start = 1'b1; move_valid = 1'b1; move_pos = 4'd0;
    q.push_back(mk(K_SNAP, 9'h000, 9'h000, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    snap();
    start = 1'b0; move_valid = 1'b0;
    q.push_back(mk(K_SNAP, 9'h000, 9'h000, 4'd0, 0, 0, 0, 0, 0, 1, 0));
    snap();

    // Reset during CHECK clears everything at once and stays idle.
    do_move(4'd0);
    rst = 1'b1;
    q.push_back(mk(K_SNAP, 9'h000, 9'h000, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    snap();
    rst = 1'b0;
    q.push_back(mk(K_SNAP, 9'h000, 9'h000, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    snap();

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
